// File: rtl/game_countdown_timer.sv
// 1 Hz game-time countdown for the mm:ss display. It supports start/restart, pause,
// saturating bonus adds and an expiry strobe. All outputs are registered.
module game_countdown_timer #(
    parameter int unsigned CLK_FREQ_HZ      = 31_500_000,
    parameter int unsigned START_SECONDS    = 60,
    parameter int unsigned MAX_SECONDS      = 2047,
    parameter int unsigned LOW_TIME_SECONDS = 10
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic        pause,
    input  logic        addTime,
    input  logic [10:0] addAmount,
    output logic [10:0] timeInSeconds,
    output logic        running,
    output logic        oneSecPulse,
    output logic        timeUp,
    output logic        lowTime
);

    localparam int unsigned      PRE_W     = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ_HZ - 1);
    localparam logic [10:0]      START_VAL = 11'(START_SECONDS);
    localparam logic [11:0]      MAX_VAL   = 12'(MAX_SECONDS);
    localparam logic [10:0]      LOW_VAL   = 11'(LOW_TIME_SECONDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [10:0]        count_q, count_d;
    logic               running_q, running_d;
    logic               one_sec_q, one_sec_d;
    logic               time_up_q, time_up_d;
    logic               low_time_q, low_time_d;

    logic               tick;
    logic               active;
    logic [11:0]        add_amt;
    logic [11:0]        sum;
    logic [10:0]        sat;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        count_d    = count_q;
        one_sec_d  = 1'b0;
        time_up_d  = 1'b0;

        active  = (state_q == S_RUNNING) || (state_q == S_PAUSED);
        tick    = (state_q == S_RUNNING) && (pre_q == PRE_LAST);
        add_amt = (addTime && active) ? {1'b0, addAmount} : 12'd0;
        // The count is never 0 while active, so subtracting the tick cannot underflow.
        sum     = {1'b0, count_q} - {11'd0, tick} + add_amt;
        sat     = (sum > MAX_VAL) ? MAX_VAL[10:0] : sum[10:0];

        if (start) begin
            state_d = S_RUNNING;
            pre_d   = '0;
            count_d = START_VAL;
        end else begin
            case (state_q)
                S_RUNNING: begin
                    pre_d     = tick ? '0 : pre_q + 1'b1;
                    count_d   = sat;
                    one_sec_d = tick;
                    if (sum == 12'd0) begin
                        state_d   = S_EXPIRED;
                        time_up_d = 1'b1;
                    end else if (pause) begin
                        state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    count_d = sat;
                    if (!pause) state_d = S_RUNNING;
                end
                default: ;
            endcase
        end

        running_d  = (state_d == S_RUNNING) || (state_d == S_PAUSED);
        low_time_d = running_d && (count_d <= LOW_VAL);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            count_q    <= START_VAL;
            running_q  <= 1'b0;
            one_sec_q  <= 1'b0;
            time_up_q  <= 1'b0;
            low_time_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            count_q    <= count_d;
            running_q  <= running_d;
            one_sec_q  <= one_sec_d;
            time_up_q  <= time_up_d;
            low_time_q <= low_time_d;
        end
    end

    assign timeInSeconds = count_q;
    assign running       = running_q;
    assign oneSecPulse   = one_sec_q;
    assign timeUp        = time_up_q;
    assign lowTime       = low_time_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer with a 10-cycle second. Directed stimulus pushes the
// expected per-second updates into a queue, and a monitor pops one on every strobe.
module tb_game_countdown_timer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic        pause;
    logic        addTime;
    logic [10:0] addAmount;
    logic [10:0] timeInSeconds;
    logic        running;
    logic        oneSecPulse;
    logic        timeUp;
    logic        lowTime;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [10:0] cnt;
        logic        one_sec;
        logic        time_up;
        logic        low;
        logic        run;
    } exp_t;

    exp_t sb_q[$];

    game_countdown_timer #(
        .CLK_FREQ_HZ     (10),
        .START_SECONDS   (60),
        .MAX_SECONDS     (2047),
        .LOW_TIME_SECONDS(10)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .pause        (pause),
        .addTime      (addTime),
        .addAmount    (addAmount),
        .timeInSeconds(timeInSeconds),
        .running      (running),
        .oneSecPulse  (oneSecPulse),
        .timeUp       (timeUp),
        .lowTime      (lowTime)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every strobe from the DUT must match the next queued expectation.
    always @(negedge clk) begin
        if (resetN && (oneSecPulse || timeUp)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", int'({oneSecPulse, timeUp}), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_count", int'(timeInSeconds), int'(e.cnt));
                check("sb_flags", int'({oneSecPulse, timeUp, lowTime, running}),
                      int'({e.one_sec, e.time_up, e.low, e.run}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_add(input logic [10:0] amt);
        addTime   = 1'b1;
        addAmount = amt;
        step();
        addTime   = 1'b0;
    endtask

    task automatic push_exp(input int cnt, input logic one, input logic up,
                            input logic low, input logic run);
        exp_t e;
        e.cnt     = 11'(cnt);
        e.one_sec = one;
        e.time_up = up;
        e.low     = low;
        e.run     = run;
        sb_q.push_back(e);
    endtask

    // Expected strobes for a plain countdown from 'hi' down to 'lo'.
    task automatic push_run(input int hi, input int lo);
        for (int s = hi; s >= lo; s--) begin
            push_exp(s, 1'b1, s == 0, (s <= 10) && (s != 0), s != 0);
        end
    endtask

    initial begin
        resetN    = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        addTime   = 1'b0;
        addAmount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", int'(timeInSeconds), 60);
        check("rst_flags", int'({running, oneSecPulse, timeUp, lowTime}), 0);
        resetN = 1'b1;

        // Idle for 100 cycles: nothing moves.
        wait_cycles(100);
        check("idle_count", int'(timeInSeconds), 60);
        check("idle_running", int'(running), 0);

        // Full countdown to expiry.
        push_run(59, 0);
        pulse_start();
        check("run_after_start", int'(running), 1);
        wait_cycles(10);
        check("first_dec", int'(timeInSeconds), 59);
        wait_cycles(90);
        check("count_at_100", int'(timeInSeconds), 50);
        wait_cycles(499);
        check("count_at_599", int'(timeInSeconds), 1);
        check("low_at_1", int'(lowTime), 1);
        wait_cycles(1);
        check("expire_count", int'(timeInSeconds), 0);
        check("expire_flags", int'({running, timeUp, lowTime}), 3'b010);
        wait_cycles(1);
        check("timeup_one_cycle", int'(timeUp), 0);
        do_add(11'd5);
        wait_cycles(1);
        check("expired_add_ignored", int'(timeInSeconds), 0);
        wait_cycles(30);
        check("expired_stays", int'(timeInSeconds), 0);
        check("expired_not_running", int'(running), 0);

        // Pause at prescaler 4 for 25 cycles; resume keeps the partial second.
        push_exp(59, 1'b1, 1'b0, 1'b0, 1'b1);
        pulse_start();
        wait_cycles(4);
        pause = 1'b1;
        wait_cycles(25);
        check("paused_count", int'(timeInSeconds), 60);
        check("paused_running", int'(running), 1);
        pause = 1'b0;
        wait_cycles(5);
        check("resume_not_yet", int'(timeInSeconds), 60);
        wait_cycles(1);
        check("resume_dec", int'(timeInSeconds), 59);

        // Saturating bonus add.
        do_add(11'd2000);
        check("add_saturate", int'(timeInSeconds), 2047);
        check("add_sat_low", int'(lowTime), 0);
        do_add(11'd5);
        check("add_at_max", int'(timeInSeconds), 2047);
        push_exp(2046, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_cycles(8);
        check("dec_from_max", int'(timeInSeconds), 2046);

        // Tick and add together at 1 second: no expiry.
        push_run(59, 1);
        push_exp(5, 1'b1, 1'b0, 1'b1, 1'b1);
        pulse_start();
        wait_cycles(599);
        check("pre_tick_add_count", int'(timeInSeconds), 1);
        addTime   = 1'b1;
        addAmount = 11'd5;
        step();
        addTime   = 1'b0;
        check("tick_add_count", int'(timeInSeconds), 5);
        check("tick_add_flags", int'({oneSecPulse, timeUp, lowTime, running}), 4'b1011);

        // Restart while running at 30; the prescaler restarts with it.
        push_run(59, 30);
        pulse_start();
        wait_cycles(300);
        check("count_at_30", int'(timeInSeconds), 30);
        wait_cycles(3);
        push_exp(59, 1'b1, 1'b0, 1'b0, 1'b1);
        pulse_start();
        check("restart_count", int'(timeInSeconds), 60);
        wait_cycles(9);
        check("restart_no_early_tick", int'(timeInSeconds), 60);
        wait_cycles(1);
        check("restart_dec", int'(timeInSeconds), 59);

        // Asynchronous reset mid-run.
        wait_cycles(3);
        resetN = 1'b0;
        #1;
        check("async_rst_count", int'(timeInSeconds), 60);
        check("async_rst_flags", int'({running, oneSecPulse, timeUp, lowTime}), 0);
        wait_cycles(2);
        resetN = 1'b1;
        wait_cycles(20);
        check("post_rst_idle", int'({timeInSeconds, running}), int'({11'd60, 1'b0}));

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
